rom_playback_seq: RTL

Address sequencer and output buffer that sits directly upstream of `sync_rom_uint`. It drives the ROM's `addr`/`ce` inputs and absorbs the ROM's 1-cycle registered read latency. ROM words are presented to downstream logic as a valid/ready stream with full backpressure. It plays a stored table (waveform, stimulus or coefficient set) from address 0 to `last_addr`, once or continuously.

---
 rtl/rom_playback_pkg.sv | 14 +
 rtl/rom_playback_seq_if.sv | 23 ++
 rtl/playback_fifo.sv | 44 ++++
 rtl/rom_playback_seq.sv | 109 ++++++++++
 4 files changed

// File: rtl/rom_playback_pkg.sv
// Shared types and constants for the ROM playback sequencer.
package rom_playback_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int PLAYBACK_FIFO_DEPTH = 4;
  localparam int OCC_BITS            = 3;
  localparam int PTR_BITS            = 2;

endpackage

// File: rtl/rom_playback_seq_if.sv
// ROM address/data bus plus the valid/ready output stream of the playback sequencer.
// master: the sequencer side; slave: the ROM + downstream consumer side.
interface rom_playback_seq_if #(
  parameter int addr_bits = 8,
  parameter int data_bits = 16
);
  logic [addr_bits-1:0] rom_addr;
  logic                 rom_ce;
  logic [data_bits-1:0] rom_data;
  logic [data_bits-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output rom_addr, rom_ce, out_data, out_valid,
    input  rom_data, out_ready
  );

  modport slave (
    input  rom_addr, rom_ce, out_data, out_valid,
    output rom_data, out_ready
  );
endinterface

// File: rtl/playback_fifo.sv
// Four-entry synchronous FIFO holding ROM words until the consumer accepts them.
// The head word is presented on rd_data whenever the FIFO is not empty.
module playback_fifo
  import rom_playback_pkg::*;
#(
  parameter int data_bits = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [data_bits-1:0] wr_data,
  input  logic                 rd_en,
  output logic [data_bits-1:0] rd_data,
  output logic [OCC_BITS-1:0]  occ,
  output logic                 empty
);

  logic [data_bits-1:0] mem [PLAYBACK_FIFO_DEPTH];
  logic [PTR_BITS-1:0]  wr_ptr;
  logic [PTR_BITS-1:0]  rd_ptr;
  logic                 do_rd;

  assign empty   = (occ == '0);
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage, pointers and occupancy; writer never targets a full FIFO thanks to upstream credit.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < PLAYBACK_FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_BITS'(1);
      end
      if (do_rd) rd_ptr <= rd_ptr + PTR_BITS'(1);
      occ <= occ + OCC_BITS'(wr_en) - OCC_BITS'(do_rd);
    end
  end

endmodule

// File: rtl/rom_playback_seq.sv
// ROM playback sequencer: walks addresses 0..last_addr into a 1-cycle-latency
// ROM and streams the returned words out with valid/ready backpressure.
// Optional feature macro: ROM_PLAYBACK_LOOP_EN (adds the loop port and
// continuous playback wrapping at last_addr until stop).
module rom_playback_seq
  import rom_playback_pkg::*;
#(
  parameter int addr_bits = 8,
  parameter int data_bits = 16,
  parameter int last_addr = 2**addr_bits-1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
`ifdef ROM_PLAYBACK_LOOP_EN
  input  logic loop,
`endif
  output logic busy,
  output logic done,
  rom_playback_seq_if.master bus
);

  state_t               state;
  logic [addr_bits-1:0] addr_q;
  logic                 pend;
  logic                 loop_q;
  logic [OCC_BITS-1:0]  occ;
  logic [OCC_BITS-1:0]  inflight;
  logic                 empty;
  logic                 pop;
  logic                 at_last;
  logic                 fifo_drained;
  logic [data_bits-1:0] fifo_head;

  // A pop in the current cycle is deliberately not credited; depth 4 still sustains one word per cycle.
  assign inflight     = occ + OCC_BITS'(pend);
  assign bus.rom_ce   = (state == RUN) && (inflight < OCC_BITS'(PLAYBACK_FIFO_DEPTH));
  assign bus.rom_addr = addr_q;
  assign at_last      = (addr_q == addr_bits'(last_addr));
  assign pop          = !empty && bus.out_ready;
  // Leave DRAIN on the edge that empties the FIFO so done lands in the first truly idle cycle.
  assign fifo_drained = !pend && (empty || ((occ == OCC_BITS'(1)) && pop));
  assign busy         = (state == RUN) || (state == DRAIN);

`ifndef ROM_PLAYBACK_LOOP_EN
  assign loop_q = 1'b0;
`endif

  // Playback FSM: address generation, in-flight tracking and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
      pend   <= 1'b0;
      done   <= 1'b0;
`ifdef ROM_PLAYBACK_LOOP_EN
      loop_q <= 1'b0;
`endif
    end else begin
      pend <= bus.rom_ce;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state  <= RUN;
            addr_q <= '0;
`ifdef ROM_PLAYBACK_LOOP_EN
            loop_q <= loop;
`endif
          end
        end
        RUN: begin
          if (bus.rom_ce) begin
            if (at_last) begin
              if (loop_q) addr_q <= '0;
              else        state  <= DRAIN;
            end else begin
              addr_q <= addr_q + addr_bits'(1);
            end
          end
          if (stop) state <= DRAIN;
        end
        DRAIN: begin
          if (fifo_drained) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  playback_fifo #(.data_bits(data_bits)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (pend),
    .wr_data (bus.rom_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .occ     (occ),
    .empty   (empty)
  );

  assign bus.out_data  = fifo_head;
  assign bus.out_valid = !empty;

endmodule
